// File: rtl/sta_out_deser.sv
// Serial deserializer for the STA datapath output: hunts for a sync word, then packs the
// following bits LSB-first into WIDTH-bit words and queues them in a 2-entry FWFT FIFO.
module sta_out_deser #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC  = WIDTH'(8'hA5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             resync,
  output logic [WIDTH-1:0] word_out,
  output logic             word_par,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             locked,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  head_q, head_d;
  logic [WIDTH-1:0]  tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [WIDTH-1:0]  sr_next;
  logic              push;
  logic              pop;

  assign sr_next = {din, sr_q[WIDTH-1:1]};

  // Framing: sync detection in HUNT, bit counting and word completion in LOCKED.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    if (din_en) begin
      sr_d = sr_next;
      case (state_q)
        StHunt: begin
          if (sr_next == SYNC) begin
            state_d   = StLocked;
            bit_cnt_d = '0;
          end
        end
        default: begin
          if (bit_cnt_q == CntLast) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      endcase
    end
    // A word completing on this edge has already been pushed above; only the framing resets.
    if (resync) begin
      state_d   = StHunt;
      bit_cnt_d = '0;
    end
  end

  assign pop = word_valid & word_ready;

  // head_q is the FIFO output register; tail_q only holds the second entry when full.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = sr_next;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = sr_next;
        end else if (push) begin
          tail_d  = sr_next;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = sr_next;
          end else begin
            count_d = 2'd1;
          end
        end else if (push) begin
          overflow_d = 1'b1;
          if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHunt;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign word_out   = head_q;
  assign word_par   = ^head_q;
  assign word_valid = (count_q != 2'd0);
  assign locked     = (state_q == StLocked);
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sta_out_deser.sv
// Bench for sta_out_deser: table-driven word vectors, directed corner sequences and a
// randomized run checked every cycle against a bit-stream/queue reference model.
module tb_sta_out_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_en;
  logic       resync;
  logic       word_ready;
  logic [7:0] word_out;
  logic       word_par;
  logic       word_valid;
  logic       locked;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sta_out_deser #(
    .WIDTH(8),
    .SYNC (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_en    (din_en),
    .resync    (resync),
    .word_out  (word_out),
    .word_par  (word_par),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .locked    (locked),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [7:0] data;
    bit         gap;
    logic [7:0] exp_word;
    bit         exp_par;
  } vec_t;

  vec_t tbl[6];

  // Reference model: raw bit history, plain counters and a word queue.
  bit         hist[$];
  bit         m_locked;
  int         m_cnt;
  logic [7:0] m_fifo[$];
  bit         m_ovf;
  int         m_drop;
  bit         src[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit d, input bit e, input bit rs, input bit rdy);
    din        = d;
    din_en     = e;
    resync     = rs;
    word_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rdy);
    for (int k = 0; k < 8; k++) cyc(b[k], 1'b1, 1'b0, rdy);
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (8) hist.push_back(1'b0);
    m_locked = 1'b0;
    m_cnt    = 0;
    m_fifo.delete();
    m_ovf    = 1'b0;
    m_drop   = 0;
  endtask

  task automatic model_step(input bit r, input bit d, input bit e, input bit rs, input bit rdy);
    logic [7:0] win;
    logic [7:0] w;
    bit         pop;
    bit         push;
    if (r) begin
      model_reset();
      return;
    end
    pop  = (m_fifo.size() > 0) && rdy;
    push = 1'b0;
    w    = 8'h00;
    if (e) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      for (int i = 0; i < 8; i++) win[i] = hist[i];
      if (m_locked) begin
        m_cnt++;
        if (m_cnt == 8) begin
          push  = 1'b1;
          w     = win;
          m_cnt = 0;
        end
      end else if (win == 8'hA5) begin
        m_locked = 1'b1;
        m_cnt    = 0;
      end
    end
    if (rs) begin
      m_locked = 1'b0;
      m_cnt    = 0;
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < 2) begin
        m_fifo.push_back(w);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic model_compare();
    check("rnd_valid", 32'(word_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      check("rnd_word", 32'(word_out), 32'(m_fifo[0]));
      check("rnd_par", 32'(word_par), 32'(^m_fifo[0]));
    end
    check("rnd_locked", 32'(locked), 32'(m_locked));
    check("rnd_overflow", 32'(overflow), 32'(m_ovf));
    check("rnd_drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_word"}, 32'(word_out), 32'd0);
    check({tag, "_par"}, 32'(word_par), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    bit r, d, e, rs, rdy;

    tbl[0] = '{data: 8'h3C, gap: 1'b0, exp_word: 8'h3C, exp_par: 1'b0};
    tbl[1] = '{data: 8'hFF, gap: 1'b1, exp_word: 8'hFF, exp_par: 1'b0};
    tbl[2] = '{data: 8'h07, gap: 1'b0, exp_word: 8'h07, exp_par: 1'b1};
    tbl[3] = '{data: 8'hA5, gap: 1'b0, exp_word: 8'hA5, exp_par: 1'b0};
    tbl[4] = '{data: 8'h01, gap: 1'b1, exp_word: 8'h01, exp_par: 1'b1};
    tbl[5] = '{data: 8'h80, gap: 1'b0, exp_word: 8'h80, exp_par: 1'b1};

    rst = 1'b0; din = 1'b0; din_en = 1'b0; resync = 1'b0; word_ready = 1'b0;
    do_reset();
    check_all_zero("reset");

    // Lock, then stream the table words back to back; each must appear one cycle after
    // its last enabled bit and be consumed on the following edge.
    b = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      cyc(b[k], 1'b1, 1'b0, 1'b1);
      if (k == 6) check("lock_early", 32'(locked), 32'd0);
    end
    check("lock_after_sync", 32'(locked), 32'd1);
    check("sync_not_pushed", 32'(word_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) begin
        cyc(tbl[i].data[k], 1'b1, 1'b0, 1'b1);
        if (k == 6) check("tbl_not_yet", 32'(word_valid), 32'd0);
        if (k < 7 && tbl[i].gap) cyc(1'($urandom), 1'b0, 1'b0, 1'b1);
      end
      check("tbl_valid", 32'(word_valid), 32'd1);
      check("tbl_word", 32'(word_out), 32'(tbl[i].exp_word));
      check("tbl_par", 32'(word_par), 32'(tbl[i].exp_par));
      check("tbl_locked", 32'(locked), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("tbl_popped", 32'(word_valid), 32'd0);
    end

    // Sync at an odd bit offset behind junk bits 1,1,0.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    b = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      cyc(b[k], 1'b1, 1'b0, 1'b1);
      if (k == 6) check("unal_lock_early", 32'(locked), 32'd0);
    end
    check("unal_lock", 32'(locked), 32'd1);
    send_byte(8'h81, 1'b1);
    check("unal_valid", 32'(word_valid), 32'd1);
    check("unal_word", 32'(word_out), 32'h81);
    check("unal_par", 32'(word_par), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("unal_single", 32'(word_valid), 32'd0);

    // Backpressure: third word is dropped, head stays stable while stalled.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    check("bp_first_valid", 32'(word_valid), 32'd1);
    check("bp_first_word", 32'(word_out), 32'h01);
    send_byte(8'h02, 1'b0);
    check("bp_stable_word", 32'(word_out), 32'h01);
    check("bp_no_ovf_yet", 32'(overflow), 32'd0);
    send_byte(8'h03, 1'b0);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_drop_cnt", 32'(drop_cnt), 32'd1);
    check("bp_head_kept", 32'(word_out), 32'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_pop2_valid", 32'(word_valid), 32'd1);
    check("bp_pop2_word", 32'(word_out), 32'h02);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_empty", 32'(word_valid), 32'd0);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-word with a word pending clears everything.
    send_byte(8'h77, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check_all_zero("midrst1");
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check_all_zero("midrst2");
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check_all_zero("postrst");

    // resync mid-word, then relock.
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("rs_unlocked", 32'(locked), 32'd0);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rs_no_word", 32'(word_valid), 32'd0);
    send_byte(8'hA5, 1'b1);
    check("rs_relock", 32'(locked), 32'd1);
    send_byte(8'h5A, 1'b1);
    check("rs_valid", 32'(word_valid), 32'd1);
    check("rs_word", 32'(word_out), 32'h5A);
    check("rs_par", 32'(word_par), 32'd0);

    // resync on the completing edge still pushes the word.
    send_byte(8'hA5, 1'b1);
    b = 8'hC3;
    for (int k = 0; k < 7; k++) cyc(b[k], 1'b1, 1'b0, 1'b1);
    cyc(b[7], 1'b1, 1'b1, 1'b1);
    check("rs_edge_unlocked", 32'(locked), 32'd0);
    check("rs_edge_valid", 32'(word_valid), 32'd1);
    check("rs_edge_word", 32'(word_out), 32'hC3);

    // Full FIFO with a pop on the completion edge: no drop.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    b = 8'h33;
    for (int k = 0; k < 7; k++) cyc(b[k], 1'b1, 1'b0, 1'b0);
    cyc(b[7], 1'b1, 1'b0, 1'b1);
    check("full_pp_overflow", 32'(overflow), 32'd0);
    check("full_pp_drop", 32'(drop_cnt), 32'd0);
    check("full_pp_head", 32'(word_out), 32'h22);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("full_pp_next", 32'(word_out), 32'h33);
    check("full_pp_next_valid", 32'(word_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("full_pp_empty", 32'(word_valid), 32'd0);

    // drop_cnt saturation: 2 stored + 257 dropped.
    do_reset();
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 259; i++) send_byte(8'(i), 1'b0);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    check("sat_overflow", 32'(overflow), 32'd1);
    check("sat_head", 32'(word_out), 32'h00);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    src.delete();
    for (int c = 0; c < 6000; c++) begin
      if (src.size() == 0) begin
        b = ($urandom % 4 == 0) ? 8'hA5 : 8'($urandom);
        for (int k = 0; k < 8; k++) src.push_back(b[k]);
      end
      r  = ($urandom % 500 == 0);
      e  = ($urandom % 4 != 0);
      d  = e ? src.pop_front() : 1'($urandom);
      rs = ($urandom % 90 == 0);
      rdy = ((c / 300) % 2 == 1) ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      model_step(r, d, e, rs, rdy);
      rst = r;
      cyc(d, e, rs, rdy);
      model_compare();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
